// File: rtl/counter_seq_ctrl_if.sv
// Host-side control/status bundle for counter_seq_ctrl.
// master: host control logic (drives requests/config, observes status).
// slave : the sequencer (consumes requests/config, drives status).
// Signals:
//   start_i, stop_i, mode_i   start/abort requests and one-shot(0)/periodic(1) select
//   prescale_i, period_i      ce divider (ce every prescale_i+1 cycles) and terminal count
//   irq_clr_i                 clears the sticky interrupt
//   ce_o, count_o, tick_o     count enable, current count, terminal-ce pulse
//   done_o, busy_o, irq_o     one-shot completion pulse, ARM/RUN flag, interrupt
interface counter_seq_ctrl_if #(
  parameter int unsigned COUNT_W    = 7,
  parameter int unsigned PRESCALE_W = 8
);
  logic                  start_i;
  logic                  stop_i;
  logic                  mode_i;
  logic [PRESCALE_W-1:0] prescale_i;
  logic [COUNT_W-1:0]    period_i;
  logic                  irq_clr_i;
  logic                  ce_o;
  logic [COUNT_W-1:0]    count_o;
  logic                  tick_o;
  logic                  done_o;
  logic                  busy_o;
  logic                  irq_o;

  modport master (
    output start_i, stop_i, mode_i, prescale_i, period_i, irq_clr_i,
    input  ce_o, count_o, tick_o, done_o, busy_o, irq_o
  );

  modport slave (
    input  start_i, stop_i, mode_i, prescale_i, period_i, irq_clr_i,
    output ce_o, count_o, tick_o, done_o, busy_o, irq_o
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencer for a count-enable driven counter datapath. Produces a prescaled ce, counts ce
// pulses against a latched period and runs one-shot or periodic, reporting terminal ticks,
// one-shot completion and an interrupt.
// Ports:
//   clk_i      rising-edge clock
//   n_reset_i  asynchronous active-low reset
//   bus_io     counter_seq_ctrl_if.slave: requests/config in, ce/count/status out
// Build option: COUNTER_SEQ_STICKY_IRQ_EN makes irq_o a sticky flag set by tick and cleared
// by irq_clr_i (set wins). Without it irq_o is a registered copy of tick_o.
module counter_seq_ctrl #(
  parameter int unsigned COUNT_W    = 7,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic               clk_i,
  input  logic               n_reset_i,
  counter_seq_ctrl_if.slave  bus_io
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StArm  = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  mode_q, mode_d;
  logic [PRESCALE_W-1:0] plim_q, plim_d;
  logic [COUNT_W-1:0]    per_q, per_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic                  ce_q, ce_d;
  logic                  tick_q, tick_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  irq_q, irq_d;

  // Outputs are registered, so every output flop is loaded with the value that belongs to the
  // cycle being entered: ce/tick are derived from the next prescaler/count/state.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    plim_d  = plim_q;
    per_d   = per_q;
    psc_d   = psc_q;
    count_d = count_q;

    unique case (state_q)
      StIdle: begin
        // stop wins over a simultaneous start
        if (bus_io.start_i && !bus_io.stop_i) begin
          mode_d  = bus_io.mode_i;
          plim_d  = bus_io.prescale_i;
          per_d   = bus_io.period_i;
          state_d = StArm;
        end
      end
      StArm: begin
        psc_d   = '0;
        count_d = '0;
        state_d = bus_io.stop_i ? StIdle : StRun;
      end
      StRun: begin
        if (bus_io.stop_i) begin
          // the ce/tick that would have been launched at this edge is dropped
          psc_d   = '0;
          count_d = '0;
          state_d = StIdle;
        end else begin
          if (ce_q) begin
            psc_d   = '0;
            count_d = (count_q == per_q) ? '0 : count_q + 1'b1;
          end else begin
            psc_d = psc_q + 1'b1;
          end
          if (tick_q && !mode_q) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    ce_d   = (state_d == StRun) && (psc_d == plim_d);
    tick_d = ce_d && (count_d == per_d);
    done_d = (state_d == StDone);
    busy_d = (state_d == StArm) || (state_d == StRun);
`ifdef COUNTER_SEQ_STICKY_IRQ_EN
    irq_d  = tick_d | (irq_q & ~bus_io.irq_clr_i);
`else
    irq_d  = tick_d;
`endif
  end

`ifndef COUNTER_SEQ_STICKY_IRQ_EN
  logic unused_irq_clr;
  assign unused_irq_clr = bus_io.irq_clr_i;
`endif

  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      plim_q  <= '0;
      per_q   <= '0;
      psc_q   <= '0;
      count_q <= '0;
      ce_q    <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      plim_q  <= plim_d;
      per_q   <= per_d;
      psc_q   <= psc_d;
      count_q <= count_d;
      ce_q    <= ce_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      irq_q   <= irq_d;
    end
  end

  assign bus_io.ce_o    = ce_q;
  assign bus_io.count_o = count_q;
  assign bus_io.tick_o  = tick_q;
  assign bus_io.done_o  = done_q;
  assign bus_io.busy_o  = busy_q;
  assign bus_io.irq_o   = irq_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl. Cycle c starts at the c-th rising edge after the
// start request is applied; inputs are driven and outputs sampled 1 time unit after the edge.
module tb_counter_seq_ctrl;

  logic clk_i;
  logic n_reset_i;
  int   total;
  int   bad;

  counter_seq_ctrl_if #(.COUNT_W(7), .PRESCALE_W(8)) bus ();

  counter_seq_ctrl #(.COUNT_W(7), .PRESCALE_W(8)) dut (
    .clk_i     (clk_i),
    .n_reset_i (n_reset_i),
    .bus_io    (bus.slave)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Compares {ce, tick, done, busy, count}; in the default build irq_o must equal tick_o.
  task automatic chk(input string tag, input int cyc, input logic ce, input logic [6:0] cnt,
                     input logic tk, input logic dn, input logic bz);
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {bus.ce_o, bus.tick_o, bus.done_o, bus.busy_o, bus.count_o};
    exp = {ce, tk, dn, bz, cnt};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d {ce,tick,done,busy,count} observed=%h expected=%h",
             tag, cyc, obs, exp);
    end
`ifndef COUNTER_SEQ_STICKY_IRQ_EN
    total++;
    assert (bus.irq_o === tk) else begin
      bad++;
      $error("FAIL %s_irq cyc=%0d observed=%b expected=%b", tag, cyc, bus.irq_o, tk);
    end
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    logic [11:0] obs;
    obs = {bus.ce_o, bus.tick_o, bus.done_o, bus.busy_o, bus.irq_o, bus.count_o};
    total++;
    assert (obs === 12'h000) else begin
      bad++;
      $error("FAIL %s observed=%h expected=000", tag, obs);
    end
  endtask

  task automatic chk_irq(input string tag, input int cyc, input logic exp);
    total++;
    assert (bus.irq_o === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d irq observed=%b expected=%b", tag, cyc, bus.irq_o, exp);
    end
  endtask

  // One-shot, P=0, N=3. With poke set: start pulses in RUN (c3) and DONE (c6), config inputs
  // change while busy, and irq_clr_i is held high; none of that may alter the sequence.
  task automatic run_p0n3(input string tag, input bit poke);
    logic       e_ce  [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    logic       e_tk  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    logic       e_dn  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    logic       e_bz  [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
    logic [6:0] e_cnt [8] = '{0, 0, 0, 1, 2, 3, 0, 0};
    for (int c = 0; c < 8; c++) begin
      bus.start_i   = (c == 0) || (poke && (c == 3 || c == 6));
      bus.irq_clr_i = poke;
      if (c == 0) begin
        bus.mode_i     = 1'b0;
        bus.prescale_i = 8'd0;
        bus.period_i   = 7'd3;
      end
      if (poke && c == 3) begin
        bus.mode_i     = 1'b1;
        bus.prescale_i = 8'd5;
        bus.period_i   = 7'd9;
      end
      chk(tag, c, e_ce[c], e_cnt[c], e_tk[c], e_dn[c], e_bz[c]);
      step();
    end
    bus.start_i   = 1'b0;
    bus.irq_clr_i = 1'b0;
  endtask

  // One-shot, P=1, N=0: tick at c3, done at c4. stop_at=2 aborts at the edge launching the tick.
  task automatic run_p1n0(input string tag, input int stop_at);
    logic e_ce [6] = '{0, 0, 0, 1, 0, 0};
    logic e_dn [6] = '{0, 0, 0, 0, 1, 0};
    logic e_bz [6] = '{0, 1, 1, 1, 0, 0};
    logic e_bs [6] = '{0, 1, 1, 0, 0, 0};
    for (int c = 0; c < 6; c++) begin
      bus.start_i    = (c == 0);
      bus.stop_i     = (c == stop_at);
      bus.mode_i     = 1'b0;
      bus.prescale_i = 8'd1;
      bus.period_i   = 7'd0;
      if (stop_at < 0) chk(tag, c, e_ce[c], 7'd0, e_ce[c], e_dn[c], e_bz[c]);
      else             chk(tag, c, 1'b0, 7'd0, 1'b0, 1'b0, e_bs[c]);
      step();
    end
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
  endtask

  initial begin
    logic       e_ce;
    logic       e_tk;
    logic       e_bz;
    logic [6:0] e_cnt;
    total          = 0;
    bad            = 0;
    n_reset_i      = 1'b0;
    bus.start_i    = 1'b0;
    bus.stop_i     = 1'b0;
    bus.mode_i     = 1'b0;
    bus.prescale_i = 8'd0;
    bus.period_i   = 7'd0;
    bus.irq_clr_i  = 1'b0;

    step();
    step();
    chk_all_zero("reset_state");
    n_reset_i = 1'b1;
    step();

    // Test 1: one-shot P=0 N=3
    run_p0n3("t1_oneshot", 1'b0);

    // Test 2: periodic P=2 N=1, ticks at 7 and 13, stop at 15 drops the ce due at 16
    for (int c = 0; c <= 20; c++) begin
      bus.start_i    = (c == 0);
      bus.stop_i     = (c == 15);
      bus.mode_i     = 1'b1;
      bus.prescale_i = 8'd2;
      bus.period_i   = 7'd1;
      e_bz  = (c >= 1) && (c <= 15);
      e_ce  = e_bz && (c >= 4) && ((c - 4) % 3 == 0);
      e_cnt = (c >= 5 && c <= 15 && ((c - 5) / 3) % 2 == 0) ? 7'd1 : 7'd0;
      e_tk  = e_ce && (e_cnt == 7'd1);
      chk("t2_periodic", c, e_ce, e_cnt, e_tk, 1'b0, e_bz);
      step();
    end
    bus.stop_i = 1'b0;
    bus.mode_i = 1'b0;

    // Test 3: P=1 N=0, then a rerun aborted just before the terminal ce
    run_p1n0("t3_p1n0", -1);
    run_p1n0("t3_stop", 2);

    // Test 4a: start with stop in IDLE is refused
    bus.start_i = 1'b1;
    bus.stop_i  = 1'b1;
    chk("t4_startstop", 0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    step();
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    chk("t4_startstop", 1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t4_startstop", 2, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);

    // Test 4b: restarts/config changes while busy and in DONE are ignored
    run_p0n3("t4_poke", 1'b1);

    // Test 5: reset while running with count_o=5 (one-shot P=0 N=7)
    for (int c = 0; c <= 7; c++) begin
      bus.start_i    = (c == 0);
      bus.mode_i     = 1'b0;
      bus.prescale_i = 8'd0;
      bus.period_i   = 7'd7;
      if (c == 7) chk("t5_before_rst", c, 1'b1, 7'd5, 1'b0, 1'b0, 1'b1);
      else        step();
    end
    n_reset_i = 1'b0;
    #1;
    chk_all_zero("t5_async_rst");
    step();
    chk_all_zero("t5_rst_held");
    n_reset_i = 1'b1;
    step();
    run_p0n3("t5_rerun", 1'b0);

`ifdef COUNTER_SEQ_STICKY_IRQ_EN
    // Test 6 (sticky): P=0 N=0 one-shot ticks at c2; irq holds until cleared at c4
    bus.irq_clr_i = 1'b1;
    step();
    for (int c = 0; c < 7; c++) begin
      bus.start_i    = (c == 0);
      bus.irq_clr_i  = (c == 4);
      bus.mode_i     = 1'b0;
      bus.prescale_i = 8'd0;
      bus.period_i   = 7'd0;
      chk_irq("t6_sticky", c, (c >= 2) && (c <= 4));
      step();
    end
    // clear sampled at the same edge as the tick: set wins
    for (int c = 0; c < 6; c++) begin
      bus.start_i   = (c == 0);
      bus.irq_clr_i = (c == 1) || (c == 4);
      chk_irq("t6_set_wins", c, (c >= 2) && (c <= 4));
      step();
    end
    bus.start_i   = 1'b0;
    bus.irq_clr_i = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
